// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one execute-stage ALU between two requesters.
// Operands are registered toward the ALU, and the result is held until the owner accepts it.
module alu_arbiter #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [DATA_W-1:0] req0_op1,
   input  logic [DATA_W-1:0] req0_op2,
   input  logic [3:0]        req0_operation,
   input  logic [4:0]        req0_shamt,
   input  logic [DATA_W-1:0] req1_op1,
   input  logic [DATA_W-1:0] req1_op2,
   input  logic [3:0]        req1_operation,
   input  logic [4:0]        req1_shamt,
   output logic [DATA_W-1:0] alu_op1,
   output logic [DATA_W-1:0] alu_op2,
   output logic [3:0]        alu_operation,
   output logic [4:0]        alu_shamt,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   input  logic              alu_overflow,
   output logic [1:0]        rsp_valid,
   input  logic [1:0]        rsp_ready,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_zero,
   output logic              rsp_overflow,
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t state, state_nxt;
   logic last_grant, owner, winner, accept, done;
   // On a tie (or no request) the requester not granted last is favoured.
   always_comb begin
      winner    = (req_valid == 2'b01) ? 1'b0 : (req_valid == 2'b10) ? 1'b1 : ~last_grant;
      req_ready = (state == IDLE) ? (winner ? 2'b10 : 2'b01) : 2'b00;
      accept    = (state == IDLE) && req_valid[winner];
      done      = (state == RESP) && rsp_ready[owner];
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = accept ? EXEC : IDLE;
         EXEC:    state_nxt = RESP;
         RESP:    state_nxt = done ? IDLE : RESP;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant    <= 1'b1;
         owner         <= 1'b0;
         alu_op1       <= '0;
         alu_op2       <= '0;
         alu_operation <= 4'h0;
         alu_shamt     <= '0;
         rsp_valid     <= 2'b00;
         rsp_result    <= '0;
         rsp_zero      <= 1'b0;
         rsp_overflow  <= 1'b0;
         busy          <= 1'b0;
      end else begin
         if (accept) begin
            last_grant    <= winner;
            owner         <= winner;
            alu_op1       <= winner ? req1_op1 : req0_op1;
            alu_op2       <= winner ? req1_op2 : req0_op2;
            alu_operation <= winner ? req1_operation : req0_operation;
            alu_shamt     <= winner ? req1_shamt : req0_shamt;
            busy          <= 1'b1;
         end
         if (state == EXEC) begin
            alu_operation <= 4'h0;
            rsp_result    <= alu_result;
            rsp_zero      <= alu_zero;
            rsp_overflow  <= alu_overflow;
            rsp_valid     <= owner ? 2'b10 : 2'b01;
         end
         if (done) begin
            rsp_valid <= 2'b00;
            busy      <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of arbitration, latency, backpressure and reset.
module tb_alu_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req_valid = 2'b00, req_ready, rsp_valid, rsp_ready = 2'b00;
   logic [31:0] req0_op1 = 0, req0_op2 = 0, req1_op1 = 0, req1_op2 = 0;
   logic [3:0]  req0_operation = 0, req1_operation = 0, alu_operation;
   logic [4:0]  req0_shamt = 0, req1_shamt = 0, alu_shamt;
   logic [31:0] alu_op1, alu_op2, alu_result, rsp_result;
   logic        alu_zero, alu_overflow, rsp_zero, rsp_overflow, busy;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   // ALU stand-in: 4'h4 add, 4'h7 subtract (op2 - op1)
   assign alu_result   = (alu_operation == 4'h4) ? alu_op1 + alu_op2 :
                         (alu_operation == 4'h7) ? alu_op2 - alu_op1 : 32'h0;
   assign alu_zero     = (alu_result == 32'h0);
   assign alu_overflow = (alu_operation == 4'h4) && (alu_op1[31] == alu_op2[31]) && (alu_result[31] != alu_op1[31]);

   alu_arbiter #(.DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_operation(req0_operation), .req0_shamt(req0_shamt),
      .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_operation(req1_operation), .req1_shamt(req1_shamt),
      .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_operation(alu_operation), .alu_shamt(alu_shamt),
      .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow), .busy(busy)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2;
      check("rst_rsp_valid", rsp_valid, 2'b00);
      check("rst_alu_operation", alu_operation, 4'h0);
      check("rst_alu_op1", alu_op1, 0);
      check("rst_alu_shamt", alu_shamt, 0);
      check("rst_rsp_result", rsp_result, 0);
      check("rst_busy", busy, 0);
      step();
      rst_n = 1'b1;
      step();
      // single add from requester 0, response held under backpressure
      req0_op1 = 5; req0_op2 = 7; req0_operation = 4'h4; req0_shamt = 5'd3;
      req_valid = 2'b01;
      #1 check("add_req_ready", req_ready, 2'b01);
      step();
      check("add_exec_op", alu_operation, 4'h4);
      check("add_exec_op1", alu_op1, 5);
      check("add_exec_shamt", alu_shamt, 3);
      check("add_exec_busy", busy, 1);
      check("add_exec_ready", req_ready, 2'b00);
      check("add_exec_rsp_valid", rsp_valid, 2'b00);
      req_valid = 2'b10;
      req1_op1 = 3; req1_op2 = 3; req1_operation = 4'h7;
      rsp_ready = 2'b10;
      step();
      check("add_rsp_valid", rsp_valid, 2'b01);
      check("add_rsp_result", rsp_result, 12);
      check("add_rsp_ovf", rsp_overflow, 0);
      check("add_op_cleared", alu_operation, 4'h0);
      check("add_op1_held", alu_op1, 5);
      for (int i = 0; i < 10; i++) begin
         step();
         check("bp_rsp_valid", rsp_valid, 2'b01);
         check("bp_rsp_result", rsp_result, 12);
         check("bp_busy", busy, 1);
         check("bp_req_ready", req_ready, 2'b00);
      end
      rsp_ready = 2'b01;
      step();
      check("hs_rsp_valid", rsp_valid, 2'b00);
      check("hs_busy", busy, 0);
      check("hs_req_ready", req_ready, 2'b10);
      step();
      check("sub_exec_op", alu_operation, 4'h7);
      check("sub_exec_op1", alu_op1, 3);
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      step();
      check("sub_rsp_valid", rsp_valid, 2'b10);
      check("sub_rsp_result", rsp_result, 0);
      check("sub_rsp_zero", rsp_zero, 1);
      rsp_ready = 2'b10;
      step();
      check("sub_done", rsp_valid, 2'b00);
      // continuous tie: grants alternate starting with requester 0
      req0_op1 = 1; req0_op2 = 1; req0_operation = 4'h4;
      req1_op1 = 2; req1_op2 = 2; req1_operation = 4'h4;
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      for (int g = 0; g < 4; g++) begin
         check("tie_ready", req_ready, (g % 2) ? 2'b10 : 2'b01);
         step();
         check("tie_op1", alu_op1, (g % 2) ? 2 : 1);
         step();
         check("tie_rsp_valid", rsp_valid, (g % 2) ? 2'b10 : 2'b01);
         check("tie_rsp_result", rsp_result, (g % 2) ? 4 : 2);
         step();
      end
      // reset during EXEC drops the operation
      req_valid = 2'b01;
      step();
      req_valid = 2'b00;
      check("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_op", alu_operation, 4'h0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_op1", alu_op1, 0);
      check("mid_rst_rsp_valid", rsp_valid, 2'b00);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("post_rst_no_rsp", rsp_valid, 2'b00);
      end
      req_valid = 2'b11;
      #1 check("post_rst_tie_ready", req_ready, 2'b01);
      step();
      check("post_rst_tie_op1", alu_op1, 1);
      req_valid = 2'b00;
      step();
      check("post_rst_rsp", rsp_valid, 2'b01);
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
